// File: rtl/loop_stack.sv
// Hardware loop stack: LIFO of {index, trip count, begin address} entries that
// drives the loop-exit decision (lstack_dontloop) for nested counted loops.
module loop_stack #(
    parameter int WORD_WIDTH         = 32,
    parameter int PROGRAM_ADDR_WIDTH = 32,
    parameter int DEPTH              = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WORD_WIDTH-1:0]         push_total,
    input  logic [PROGRAM_ADDR_WIDTH-1:0] push_address,
    input  logic                          pop,
    input  logic                          loop,
    output logic                          lstack_dontloop,
    output logic [WORD_WIDTH-1:0]         lstack_index,
    output logic [WORD_WIDTH-1:0]         lstack_total,
    output logic [PROGRAM_ADDR_WIDTH-1:0] lstack_address,
    output logic [$clog2(DEPTH):0]        lstack_depth,
    output logic                          lstack_empty,
    output logic                          lstack_full,
    output logic                          lstack_overflow,
    output logic                          lstack_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WORD_WIDTH-1:0]         r_index [DEPTH];
    logic [WORD_WIDTH-1:0]         r_total [DEPTH];
    logic [PROGRAM_ADDR_WIDTH-1:0] r_addr  [DEPTH];
    logic [DW-1:0]                 r_depth;
    logic                          r_overflow;
    logic                          r_underflow;

    logic          w_empty;
    logic          w_full;
    logic [AW-1:0] w_top_ptr;
    logic          w_dontloop;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_ptr;
    logic          w_inc_en;
    logic [DW-1:0] w_depth_next;
    logic          w_ovf_set;
    logic          w_unf_set;

    assign w_empty   = (r_depth == '0);
    assign w_full    = (r_depth == DW'(DEPTH));
    assign w_top_ptr = AW'(r_depth - DW'(1));

    // Top-of-stack view is purely a function of registered state.
    assign lstack_index    = w_empty ? '0 : r_index[w_top_ptr];
    assign lstack_total    = w_empty ? '0 : r_total[w_top_ptr];
    assign lstack_address  = w_empty ? '0 : r_addr[w_top_ptr];
    assign w_dontloop      = w_empty | (lstack_index >= lstack_total);
    assign lstack_dontloop = w_dontloop;
    assign lstack_depth    = r_depth;
    assign lstack_empty    = w_empty;
    assign lstack_full     = w_full;
    assign lstack_overflow  = r_overflow;
    assign lstack_underflow = r_underflow;

    always_comb begin
        w_wr_en      = 1'b0;
        w_wr_ptr     = w_top_ptr;
        w_inc_en     = 1'b0;
        w_depth_next = r_depth;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        if (push && pop) begin
            // Replace top; on an empty stack this degrades to a plain push.
            w_wr_en = 1'b1;
            if (w_empty) begin
                w_wr_ptr     = '0;
                w_depth_next = DW'(1);
                w_unf_set    = 1'b1;
            end
        end else if (push) begin
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_wr_en      = 1'b1;
                w_wr_ptr     = AW'(r_depth);
                w_depth_next = r_depth + DW'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_depth_next = r_depth - DW'(1);
            end
        end else if (loop && !w_empty) begin
            if (w_dontloop) begin
                w_depth_next = r_depth - DW'(1);
            end else begin
                w_inc_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_index[i] <= '0;
                r_total[i] <= '0;
                r_addr[i]  <= '0;
            end
        end else begin
            r_depth <= w_depth_next;
            if (w_ovf_set) r_overflow  <= 1'b1;
            if (w_unf_set) r_underflow <= 1'b1;
            if (w_wr_en) begin
                r_index[w_wr_ptr] <= '0;
                r_total[w_wr_ptr] <= push_total;
                r_addr[w_wr_ptr]  <= push_address;
            end else if (w_inc_en) begin
                r_index[w_top_ptr] <= r_index[w_top_ptr] + WORD_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_loop_stack.sv
// Directed self-checking bench for loop_stack (DEPTH=8, 32-bit words/addresses).
module tb_loop_stack;

    logic        clk;
    logic        reset;
    logic        push;
    logic [31:0] push_total;
    logic [31:0] push_address;
    logic        pop;
    logic        loop;
    logic        lstack_dontloop;
    logic [31:0] lstack_index;
    logic [31:0] lstack_total;
    logic [31:0] lstack_address;
    logic [3:0]  lstack_depth;
    logic        lstack_empty;
    logic        lstack_full;
    logic        lstack_overflow;
    logic        lstack_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    loop_stack #(
        .WORD_WIDTH(32),
        .PROGRAM_ADDR_WIDTH(32),
        .DEPTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .push_total(push_total),
        .push_address(push_address),
        .pop(pop),
        .loop(loop),
        .lstack_dontloop(lstack_dontloop),
        .lstack_index(lstack_index),
        .lstack_total(lstack_total),
        .lstack_address(lstack_address),
        .lstack_depth(lstack_depth),
        .lstack_empty(lstack_empty),
        .lstack_full(lstack_full),
        .lstack_overflow(lstack_overflow),
        .lstack_underflow(lstack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; outputs are checked 1 time unit after the edge.
    task automatic cyc(input logic p, input logic q, input logic l,
                       input logic [31:0] tot, input logic [31:0] adr);
        push = p; pop = q; loop = l; push_total = tot; push_address = adr;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; loop = 1'b0;
        $display("[TB] t=%0t push=%0b pop=%0b loop=%0b tot=%0d adr=%0h -> depth=%0d idx=%0d tot=%0d adr=%0h dl=%0b ovf=%0b unf=%0b",
                 $time, p, q, l, tot, adr, lstack_depth, lstack_index, lstack_total,
                 lstack_address, lstack_dontloop, lstack_overflow, lstack_underflow);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        chk("rst_depth", 64'(lstack_depth), 64'd0);
        chk("rst_dontloop", 64'(lstack_dontloop), 64'd1);
        chk("rst_empty", 64'(lstack_empty), 64'd1);
        chk("rst_full", 64'(lstack_full), 64'd0);
        chk("rst_index", 64'(lstack_index), 64'd0);
        chk("rst_total", 64'(lstack_total), 64'd0);
        chk("rst_address", 64'(lstack_address), 64'd0);
        chk("rst_overflow", 64'(lstack_overflow), 64'd0);
        chk("rst_underflow", 64'(lstack_underflow), 64'd0);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; loop = 1'b0;
        push_total = '0; push_address = '0;
        reset = 1'b1;
        #3;
        chk("init_depth", 64'(lstack_depth), 64'd0);
        chk("init_dontloop", 64'(lstack_dontloop), 64'd1);
        chk("init_empty", 64'(lstack_empty), 64'd1);
        chk("init_full", 64'(lstack_full), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Counted loop, total=3
        cyc(1, 0, 0, 32'd3, 32'h40);
        chk("cnt_push_dl", 64'(lstack_dontloop), 64'd0);
        chk("cnt_push_adr", 64'(lstack_address), 64'h40);
        chk("cnt_push_idx", 64'(lstack_index), 64'd0);
        chk("cnt_push_depth", 64'(lstack_depth), 64'd1);
        cyc(0, 0, 1, 32'd0, 32'h0);
        chk("cnt_l1_idx", 64'(lstack_index), 64'd1);
        chk("cnt_l1_dl", 64'(lstack_dontloop), 64'd0);
        cyc(0, 0, 1, 32'd0, 32'h0);
        chk("cnt_l2_idx", 64'(lstack_index), 64'd2);
        cyc(0, 0, 1, 32'd0, 32'h0);
        chk("cnt_l3_idx", 64'(lstack_index), 64'd3);
        chk("cnt_l3_dl", 64'(lstack_dontloop), 64'd1);
        cyc(0, 0, 1, 32'd0, 32'h0);
        chk("cnt_l4_empty", 64'(lstack_empty), 64'd1);
        chk("cnt_l4_depth", 64'(lstack_depth), 64'd0);

        // Nesting with an inner zero-trip loop
        cyc(1, 0, 0, 32'd2, 32'h10);
        cyc(1, 0, 0, 32'd0, 32'h20);
        chk("nest_dl", 64'(lstack_dontloop), 64'd1);
        chk("nest_adr", 64'(lstack_address), 64'h20);
        chk("nest_depth", 64'(lstack_depth), 64'd2);
        cyc(0, 0, 1, 32'd0, 32'h0);
        chk("nest_pop_adr", 64'(lstack_address), 64'h10);
        chk("nest_pop_idx", 64'(lstack_index), 64'd0);
        chk("nest_pop_tot", 64'(lstack_total), 64'd2);
        chk("nest_pop_dl", 64'(lstack_dontloop), 64'd0);
        chk("nest_pop_depth", 64'(lstack_depth), 64'd1);
        cyc(0, 1, 0, 32'd0, 32'h0);
        chk("nest_break_empty", 64'(lstack_empty), 64'd1);

        // Fill to DEPTH, then overflow and replace-while-full
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 32'(10 + i), 32'(32'h100 + i));
        chk("full_flag", 64'(lstack_full), 64'd1);
        chk("full_depth", 64'(lstack_depth), 64'd8);
        chk("full_tot", 64'(lstack_total), 64'd17);
        cyc(1, 0, 0, 32'd99, 32'h999);
        chk("ovf_flag", 64'(lstack_overflow), 64'd1);
        chk("ovf_depth", 64'(lstack_depth), 64'd8);
        chk("ovf_tot", 64'(lstack_total), 64'd17);
        chk("ovf_adr", 64'(lstack_address), 64'h107);
        cyc(1, 1, 0, 32'd5, 32'h200);
        chk("repl_tot", 64'(lstack_total), 64'd5);
        chk("repl_adr", 64'(lstack_address), 64'h200);
        chk("repl_depth", 64'(lstack_depth), 64'd8);
        chk("repl_ovf", 64'(lstack_overflow), 64'd1);
        cyc(0, 1, 0, 32'd0, 32'h0);
        chk("lower_tot", 64'(lstack_total), 64'd16);
        chk("lower_adr", 64'(lstack_address), 64'h106);
        chk("lower_depth", 64'(lstack_depth), 64'd7);

        // Asynchronous reset mid-stream (between clock edges)
        pulse_reset();

        // Underflow and push-with-loop
        cyc(0, 1, 0, 32'd0, 32'h0);
        chk("unf_flag", 64'(lstack_underflow), 64'd1);
        chk("unf_depth", 64'(lstack_depth), 64'd0);
        cyc(1, 0, 1, 32'd1, 32'h30);
        chk("pl_depth", 64'(lstack_depth), 64'd1);
        chk("pl_idx", 64'(lstack_index), 64'd0);
        chk("pl_dl", 64'(lstack_dontloop), 64'd0);
        cyc(0, 0, 1, 32'd0, 32'h0);
        chk("pl_l1_idx", 64'(lstack_index), 64'd1);
        chk("pl_l1_dl", 64'(lstack_dontloop), 64'd1);
        chk("pl_l1_depth", 64'(lstack_depth), 64'd1);

        // Loops while empty leave everything alone
        pulse_reset();
        cyc(0, 0, 1, 32'd0, 32'h0);
        cyc(0, 0, 1, 32'd0, 32'h0);
        chk("eloop_depth", 64'(lstack_depth), 64'd0);
        chk("eloop_dl", 64'(lstack_dontloop), 64'd1);
        chk("eloop_unf", 64'(lstack_underflow), 64'd0);
        chk("eloop_ovf", 64'(lstack_overflow), 64'd0);

        // push+pop on empty stack acts as push and flags underflow
        cyc(1, 1, 0, 32'd4, 32'h50);
        chk("pp_empty_depth", 64'(lstack_depth), 64'd1);
        chk("pp_empty_tot", 64'(lstack_total), 64'd4);
        chk("pp_empty_adr", 64'(lstack_address), 64'h50);
        chk("pp_empty_unf", 64'(lstack_underflow), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
